// File: rtl/wedding_light_3.sv
// 16-LED decorative pattern generator: off, chase, bounce and Johnson fill/empty at selectable speed.
// Define WEDDING_LIGHT_ACTIVE_LOW_EN to drive q inverted for active-low LED hardware.
module wedding_light_3 #(
    parameter int unsigned N_LEDS = 16,
    parameter int unsigned SPD_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SPD_W+1:0]    load,
    output logic [N_LEDS-1:0]   q
);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

    logic [N_LEDS-1:0] pat_q, pat_d, step_pat;
    logic [1:0]        mode_q, mode_new;
    logic [SPD_W-1:0]  spd_q, spd_new;
    logic [SPD_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d, step_dir;
    logic              pat_onehot;

    assign mode_new   = load[1:0];
    assign spd_new    = load[SPD_W+1:2];
    assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - ONE)) == '0);

    // Next pattern if a step fires this edge; non-one-hot values in chase/bounce reload init.
    always_comb begin
        step_pat = pat_q;
        step_dir = dir_q;
        case (mode_q)
            MODE_CHASE: begin
                if (!pat_onehot) begin
                    step_pat = ONE;
                end else begin
                    step_pat = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
                end
            end
            MODE_BOUNCE: begin
                if (!pat_onehot) begin
                    step_pat = ONE;
                    step_dir = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    if (pat_q[N_LEDS-1]) begin
                        step_pat = pat_q >> 1;
                        step_dir = DIR_RIGHT;
                    end else begin
                        step_pat = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        step_pat = pat_q << 1;
                        step_dir = DIR_LEFT;
                    end else begin
                        step_pat = pat_q >> 1;
                    end
                end
            end
            MODE_FILL: begin
                step_pat = {pat_q[N_LEDS-2:0], ~pat_q[N_LEDS-1]};
            end
            default: begin
                step_pat = '0;
            end
        endcase
    end

    always_comb begin
        pat_d = pat_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (mode_new != mode_q) begin
            pat_d = (mode_new == MODE_OFF) ? '0 : ONE;
            cnt_d = '0;
            dir_d = DIR_LEFT;
        end else if (mode_q == MODE_OFF) begin
            pat_d = '0;
            cnt_d = '0;
        end else if (cnt_q >= spd_q) begin
            // >= so that lowering the speed below the running count still steps
            pat_d = step_pat;
            dir_d = step_dir;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + SPD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            mode_q <= MODE_OFF;
            spd_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_LEFT;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_new;
            spd_q  <= spd_new;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

`ifdef WEDDING_LIGHT_ACTIVE_LOW_EN
    assign q = ~pat_q;
`else
    assign q = pat_q;
`endif

endmodule

// File: tb/tb_wedding_light_3.sv
// Self-checking bench for wedding_light_3: a behavioural model pushes the expected LED word for
// every driven clock into a queue, which is popped and compared after the edge.
module tb_wedding_light_3;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   load = 5'b0;
    logic [N-1:0] q;

    int n_checks = 0;
    int n_fails  = 0;

    logic [N-1:0] exp_q[$];

    // Behavioural model state
    logic [N-1:0] m_pat;
    logic [1:0]   m_mode;
    logic [2:0]   m_spd;
    int           m_cnt;
    int           m_pos;
    bit           m_right;

    wedding_light_3 #(.N_LEDS(N), .SPD_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .q    (q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] exp_out(input logic [N-1:0] pat);
`ifdef WEDDING_LIGHT_ACTIVE_LOW_EN
        return ~pat;
`else
        return pat;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%04h, want 0x%04h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = '0; m_mode = 2'b00; m_spd = 3'd0; m_cnt = 0; m_pos = 0; m_right = 1'b0;
    endtask

    task automatic model_step();
        case (m_mode)
            2'b01: begin
                m_pos = (m_pos + 1) % N;
                m_pat = N'(1) << m_pos;
            end
            2'b10: begin
                if (!m_right) begin
                    if (m_pos == N - 1) begin m_right = 1'b1; m_pos = N - 2; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_pos == 0) begin m_right = 1'b0; m_pos = 1; end
                    else m_pos = m_pos - 1;
                end
                m_pat = N'(1) << m_pos;
            end
            default: m_pat = {m_pat[N-2:0], ~m_pat[N-1]};
        endcase
    endtask

    task automatic model_edge(input logic [4:0] ld);
        if (ld[1:0] != m_mode) begin
            m_pat = (ld[1:0] == 2'b00) ? '0 : N'(1);
            m_cnt = 0; m_pos = 0; m_right = 1'b0;
        end else if (m_mode == 2'b00) begin
            m_pat = '0; m_cnt = 0;
        end else if (m_cnt >= int'(m_spd)) begin
            model_step();
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_mode = ld[1:0];
        m_spd  = ld[4:2];
    endtask

    // Drive one clock of stimulus, push expectation, pop and compare after the edge.
    task automatic cyc(input logic [4:0] ld, input string tag);
        logic [N-1:0] want;
        load = ld;
        model_edge(ld);
        exp_q.push_back(exp_out(m_pat));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, q, ~q);
        end else begin
            want = exp_q.pop_front();
            check_eq(tag, q, want);
        end
    endtask

    initial begin
        model_reset();
        rst  = 1'b1;
        load = 5'b11011;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold", q, exp_out(16'h0000));
        end
        rst = 1'b0;
        cyc(5'b11011, "release");
        check_eq("release_init", q, exp_out(16'h0001));

        for (int i = 0; i < 4; i++) cyc(5'b00000, "idle");
        check_eq("idle_off", q, exp_out(16'h0000));

        // Johnson, S=6: one step every 7 clocks
        cyc(5'b11011, "fill_start");
        check_eq("fill_first", q, exp_out(16'h0001));
        for (int i = 0; i < 7; i++) cyc(5'b11011, "fill");
        check_eq("fill_0003", q, exp_out(16'h0003));
        for (int i = 0; i < 7; i++) cyc(5'b11011, "fill");
        check_eq("fill_0007", q, exp_out(16'h0007));
        for (int i = 0; i < 7 * 13; i++) cyc(5'b11011, "fill");
        check_eq("fill_ffff", q, exp_out(16'hFFFF));
        for (int i = 0; i < 7 * 16; i++) cyc(5'b11011, "fill");
        check_eq("fill_0000", q, exp_out(16'h0000));
        cyc(5'b11011, "fill");

        // Chase, S=0: two full periods
        for (int i = 0; i < 33; i++) cyc(5'b00001, "chase");
        check_eq("chase_wrap", q, exp_out(16'h0001));

        // Bounce, S=1: more than one full 30-step period
        for (int i = 0; i < 31; i++) cyc(5'b00110, "bounce");
        check_eq("bounce_top", q, exp_out(16'h8000));
        for (int i = 0; i < 2; i++) cyc(5'b00110, "bounce");
        check_eq("bounce_turn", q, exp_out(16'h4000));
        for (int i = 0; i < 28; i++) cyc(5'b00110, "bounce");
        check_eq("bounce_bottom", q, exp_out(16'h0001));
        for (int i = 0; i < 2; i++) cyc(5'b00110, "bounce");
        check_eq("bounce_rise", q, exp_out(16'h0002));

        // Chase S=7, lower speed to S=2 at cnt=5
        for (int i = 0; i < 6; i++) cyc(5'b11101, "spd_slow");
        for (int i = 0; i < 10; i++) cyc(5'b01001, "spd_fast");
        cyc(5'b01011, "mode_switch");
        check_eq("mode_switch_init", q, exp_out(16'h0001));
        for (int i = 0; i < 8; i++) cyc(5'b01011, "after_switch");

        // Asynchronous reset between edges during bounce
        for (int i = 0; i < 11; i++) cyc(5'b00110, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst", q, exp_out(16'h0000));
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_held", q, exp_out(16'h0000));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(5'b00110, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
